// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the 2-master/3-slave matrix.
// Transfer types, responses, slave indices and the address map.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        SLV_G,
        SLV_T,
        SLV_R,
        SLV_DEF
    } slv_idx_e;

    localparam logic [3:0] ADDR_NIB_G = 4'h0;
    localparam logic [3:0] ADDR_NIB_T = 4'h1;
    localparam logic [3:0] ADDR_NIB_R = 4'h2;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } def_state_e;

    function automatic logic htrans_active(input logic [1:0] t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped transfers.
// sel_dp pulses on the edge that hands it a data phase.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic HCLK,
    input  logic HRESETn,
    input  logic sel_dp,
    output logic hreadyout,
    output logic hresp
);

    def_state_e state, state_nx;

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= DS_IDLE;
        else          state <= state_nx;
    end

    // Next state and response outputs
    always_comb begin
        state_nx  = state;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state)
            DS_IDLE: begin
                if (sel_dp) state_nx = DS_ERR1;
            end
            DS_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_nx  = DS_ERR2;
            end
            DS_ERR2: begin
                hresp    = HRESP_ERROR;
                state_nx = sel_dp ? DS_ERR1 : DS_IDLE;
            end
            default: state_nx = DS_IDLE;
        endcase
    end

endmodule

// File: rtl/ahb_resp_mux.sv
// Return-path mux for one master port: registers the address-phase
// select into the data phase and routes the owning slave back.
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  DEF_RDATA = '0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL_G,
    input  logic              HSEL_T,
    input  logic              HSEL_R,
    input  logic [1:0]        HTRANS,
    input  logic [DATA_W-1:0] HRDATA_G,
    input  logic [DATA_W-1:0] HRDATA_T,
    input  logic [DATA_W-1:0] HRDATA_R,
    input  logic              HREADYOUT_G,
    input  logic              HREADYOUT_T,
    input  logic              HREADYOUT_R,
    input  logic              HRESP_G,
    input  logic              HRESP_T,
    input  logic              HRESP_R,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADY,
    output logic              HRESP
);

    logic [3:0] dsel;
    logic [3:0] dsel_nx;
    logic       load_def;
    logic       def_ready;
    logic       def_resp;

    // Address-phase owner; G>T>R only matters for illegal multi-select
    always_comb begin
        dsel_nx = '0;
        if (HSEL_G)                     dsel_nx[SLV_G]   = 1'b1;
        else if (HSEL_T)                dsel_nx[SLV_T]   = 1'b1;
        else if (HSEL_R)                dsel_nx[SLV_R]   = 1'b1;
        else if (htrans_active(HTRANS)) dsel_nx[SLV_DEF] = 1'b1;
    end

    assign load_def = HREADY & dsel_nx[SLV_DEF];

    // Data-phase owner advances only when the current data phase completes
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)    dsel <= '0;
        else if (HREADY) dsel <= dsel_nx;
    end

    ahb_default_slave u_def (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .sel_dp    (load_def),
        .hreadyout (def_ready),
        .hresp     (def_resp)
    );

    // Response mux; no owner means a zero-wait OKAY
    always_comb begin
        HRDATA = DEF_RDATA;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        unique case (1'b1)
            dsel[SLV_G]: begin
                HRDATA = HRDATA_G;
                HREADY = HREADYOUT_G;
                HRESP  = HRESP_G;
            end
            dsel[SLV_T]: begin
                HRDATA = HRDATA_T;
                HREADY = HREADYOUT_T;
                HRESP  = HRESP_T;
            end
            dsel[SLV_R]: begin
                HRDATA = HRDATA_R;
                HREADY = HREADYOUT_R;
                HRESP  = HRESP_R;
            end
            dsel[SLV_DEF]: begin
                HREADY = def_ready;
                HRESP  = def_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed bench for ahb_resp_mux: per-cycle vector table plus
// hand sequences for async reset and a plain G read.
module tb_ahb_resp_mux;

    logic        clk;
    logic        rst_n;
    logic        hsel_g, hsel_t, hsel_r;
    logic [1:0]  htrans;
    logic [31:0] rd_g, rd_t, rd_r;
    logic        rdy_g, rdy_t, rdy_r;
    logic        rsp_g, rsp_t, rsp_r;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int total = 0;
    int bad   = 0;

    ahb_resp_mux #(.DATA_W(32), .DEF_RDATA(32'h0)) dut (
        .HCLK        (clk),
        .HRESETn     (rst_n),
        .HSEL_G      (hsel_g),
        .HSEL_T      (hsel_t),
        .HSEL_R      (hsel_r),
        .HTRANS      (htrans),
        .HRDATA_G    (rd_g),
        .HRDATA_T    (rd_t),
        .HRDATA_R    (rd_r),
        .HREADYOUT_G (rdy_g),
        .HREADYOUT_T (rdy_t),
        .HREADYOUT_R (rdy_r),
        .HRESP_G     (rsp_g),
        .HRESP_T     (rsp_t),
        .HRESP_R     (rsp_r),
        .HRDATA      (hrdata),
        .HREADY      (hready),
        .HRESP       (hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // src: 0 = zero data, 1 = G, 2 = T, 3 = R
    typedef struct {
        logic [2:0] hsel;
        logic [1:0] htrans;
        logic [2:0] rdy;
        logic [2:0] rsp;
        int         src;
        logic       e_rdy;
        logic       e_rsp;
    } vec_t;

    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] BSY = 2'b01;
    localparam logic [1:0] NSQ = 2'b10;
    localparam logic [1:0] SQ  = 2'b11;

    vec_t tbl[$];

    task automatic add(input logic [2:0] hs, input logic [1:0] tr,
                       input logic [2:0] rd, input logic [2:0] rs,
                       input int s, input logic er, input logic ep);
        vec_t v;
        v.hsel = hs; v.htrans = tr; v.rdy = rd; v.rsp = rs;
        v.src = s; v.e_rdy = er; v.e_rsp = ep;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] hs, input logic [1:0] tr,
                         input logic [2:0] rd, input logic [2:0] rs,
                         input int row);
        {hsel_r, hsel_t, hsel_g} = hs;
        htrans = tr;
        {rdy_r, rdy_t, rdy_g} = rd;
        {rsp_r, rsp_t, rsp_g} = rs;
        rd_g = 32'hA000_0000 + row;
        rd_t = 32'hB000_0000 + row;
        rd_r = 32'hC000_0000 + row;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_d;
        string nm;

        // hsel {R,T,G}, htrans, rdy {R,T,G}, rsp {R,T,G}, src, rdy, rsp
        add(3'b001, NSQ, 3'b000, 3'b111, 0, 1'b1, 1'b0);
        add(3'b010, NSQ, 3'b001, 3'b110, 1, 1'b1, 1'b0);
        add(3'b100, NSQ, 3'b101, 3'b000, 2, 1'b0, 1'b0);
        add(3'b100, NSQ, 3'b101, 3'b000, 2, 1'b0, 1'b0);
        add(3'b100, NSQ, 3'b101, 3'b000, 2, 1'b0, 1'b0);
        add(3'b100, NSQ, 3'b010, 3'b101, 2, 1'b1, 1'b0);
        add(3'b000, NSQ, 3'b100, 3'b011, 3, 1'b1, 1'b0);
        add(3'b000, IDL, 3'b111, 3'b000, 0, 1'b0, 1'b1);
        add(3'b000, IDL, 3'b000, 3'b000, 0, 1'b1, 1'b1);
        add(3'b000, NSQ, 3'b000, 3'b111, 0, 1'b1, 1'b0);
        add(3'b000, SQ,  3'b111, 3'b000, 0, 1'b0, 1'b1);
        add(3'b000, SQ,  3'b111, 3'b000, 0, 1'b1, 1'b1);
        add(3'b001, NSQ, 3'b111, 3'b000, 0, 1'b0, 1'b1);
        add(3'b001, NSQ, 3'b000, 3'b000, 0, 1'b1, 1'b1);
        add(3'b000, BSY, 3'b110, 3'b001, 1, 1'b0, 1'b1);
        add(3'b000, BSY, 3'b001, 3'b001, 1, 1'b1, 1'b1);
        add(3'b001, NSQ, 3'b000, 3'b111, 0, 1'b1, 1'b0);
        add(3'b010, SQ,  3'b001, 3'b000, 1, 1'b1, 1'b0);
        add(3'b100, NSQ, 3'b010, 3'b000, 2, 1'b1, 1'b0);
        add(3'b000, IDL, 3'b100, 3'b000, 3, 1'b1, 1'b0);
        add(3'b000, IDL, 3'b000, 3'b111, 0, 1'b1, 1'b0);

        // Async reset with arbitrary inputs, mid-cycle
        rst_n = 1'b1;
        drive(3'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 99);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(hready), 32'h1);
        chk("rst_resp",  32'(hresp),  32'h0);
        chk("rst_data",  hrdata,      32'h0);
        drive(3'b000, IDL, 3'b000, 3'b000, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Vector table: inputs applied after the edge, checked at negedge
        foreach (tbl[i]) begin
            drive(tbl[i].hsel, tbl[i].htrans, tbl[i].rdy, tbl[i].rsp, i);
            @(negedge clk);
            case (tbl[i].src)
                1:       exp_d = 32'hA000_0000 + i;
                2:       exp_d = 32'hB000_0000 + i;
                3:       exp_d = 32'hC000_0000 + i;
                default: exp_d = 32'h0;
            endcase
            nm = $sformatf("row%0d", i);
            chk({nm, "_data"},  hrdata,      exp_d);
            chk({nm, "_ready"}, 32'(hready), 32'(tbl[i].e_rdy));
            chk({nm, "_resp"},  32'(hresp),  32'(tbl[i].e_rsp));
            next_cycle();
        end

        // Reset during ERR1 releases the bus immediately
        drive(3'b000, NSQ, 3'b111, 3'b000, 0);
        next_cycle();
        drive(3'b000, NSQ, 3'b111, 3'b000, 0);
        #2;
        chk("err1_ready", 32'(hready), 32'h0);
        chk("err1_resp",  32'(hresp),  32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready", 32'(hready), 32'h1);
        chk("rstmid_resp",  32'(hresp),  32'h0);
        drive(3'b000, IDL, 3'b000, 3'b000, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Plain G read after reset release
        drive(3'b001, NSQ, 3'b000, 3'b000, 0);
        @(negedge clk);
        chk("g_addr_ready", 32'(hready), 32'h1);
        next_cycle();
        drive(3'b000, IDL, 3'b001, 3'b000, 0);
        rd_g = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("g_read_data",  hrdata,      32'hDEAD_BEEF);
        chk("g_read_ready", 32'(hready), 32'h1);
        chk("g_read_resp",  32'(hresp),  32'h0);
        next_cycle();
        drive(3'b000, IDL, 3'b000, 3'b111, 0);
        @(negedge clk);
        chk("g_after_data",  hrdata,      32'h0);
        chk("g_after_ready", 32'(hready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
